// File: rtl/man_mul_iter.sv
// Iterative radix-2^RADIX_BITS mantissa multiplier with product normalisation and RNE decision.
// Build option: define MAN_MUL_ROUND_APPLY_EN to apply the rounding increment inside the block.
`timescale 1ns/1ps
module man_mul_iter #(
  parameter int SIZE_DATA  = 24,
  parameter int RADIX_BITS = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic [SIZE_DATA-1:0] i_data_b,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_data_mul,
  output logic                 o_over_flag,
  output logic                 o_rounding
);

  localparam int N  = SIZE_DATA;
  localparam int K  = SIZE_DATA / RADIX_BITS;
  localparam int CW = (K < 2) ? 1 : $clog2(K + 1);

  if (SIZE_DATA < 4 || (SIZE_DATA % RADIX_BITS) != 0 || RADIX_BITS < 1) begin : g_param_chk
    $error("man_mul_iter: SIZE_DATA must be >= 4 and divisible by RADIX_BITS");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q;
  logic [2*N-1:0]    mcand_q;
  logic [N-1:0]      mplier_q;
  logic [2*N-1:0]    prod_q;
  logic [CW-1:0]     cnt_q;
  logic [N-1:0]      data_q;
  logic              ovf_q;
  logic              rnd_q;

  logic [2*N-1:0]    pp;
  logic [2*N-1:0]    prod_d;
  logic [N-1:0]      man;
  logic              guard;
  logic              sticky;
  logic              top_set;
  logic              inc;
  logic [N-1:0]      data_d;
  logic              ovf_d;
  logic              rnd_d;
`ifdef MAN_MUL_ROUND_APPLY_EN
  logic [N:0]        man_rnd;
`endif

  function automatic logic rne_inc(input logic lsb, input logic g, input logic s);
    return g & (s | lsb);
  endfunction

  // Partial product of the current radix digit: the multiplicand is pre-shifted
  // by the iteration weight, so only shifts by 0..RADIX_BITS-1 remain here.
  always_comb begin
    pp = '0;
    for (int j = 0; j < RADIX_BITS; j++) begin
      if (mplier_q[j]) pp = pp + (mcand_q << j);
    end
    prod_d = prod_q + pp;
  end

  // The leading one of a product of two normalised mantissas sits in bit 2N-1 or 2N-2.
  always_comb begin
    top_set = prod_q[2*N-1];
    if (top_set) begin
      man    = prod_q[2*N-1 -: N];
      guard  = prod_q[N-1];
      sticky = |prod_q[N-2:0];
    end else begin
      man    = prod_q[2*N-2 -: N];
      guard  = prod_q[N-2];
      sticky = |prod_q[N-3:0];
    end
    inc   = rne_inc(man[0], guard, sticky);
    rnd_d = inc;
`ifdef MAN_MUL_ROUND_APPLY_EN
    man_rnd = {1'b0, man} + {{N{1'b0}}, inc};
    if (man_rnd[N]) begin
      data_d = {1'b1, {(N-1){1'b0}}};
      ovf_d  = 1'b1;
    end else begin
      data_d = man_rnd[N-1:0];
      ovf_d  = top_set;
    end
`else
    data_d = man;
    ovf_d  = top_set;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      rnd_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            mcand_q  <= {{N{1'b0}}, i_data_a};
            mplier_q <= i_data_b;
            prod_q   <= '0;
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << RADIX_BITS;
          mplier_q <= mplier_q >> RADIX_BITS;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(K - 1)) state_q <= NORM;
        end
        NORM: begin
          data_q  <= data_d;
          ovf_q   <= ovf_d;
          rnd_q   <= rnd_d;
          state_q <= DONE;
        end
        DONE: begin
          if (i_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_valid     = (state_q == DONE);
  assign o_data_mul  = data_q;
  assign o_over_flag = ovf_q;
  assign o_rounding  = rnd_q;

endmodule

// File: tb/tb_man_mul_iter.sv
// Directed bench for man_mul_iter: default radix plus RADIX_BITS 1/3/4 instances for latency.
`timescale 1ns/1ps
module tb_man_mul_iter;

  localparam int N = 24;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b0;
  logic         aux_valid = 1'b0;
  logic [N-1:0] i_data_a = '0;
  logic [N-1:0] i_data_b = '0;
  logic         o_ready, o_valid, o_over_flag, o_rounding;
  logic [N-1:0] o_data_mul;
  logic [2:0]   ax_ready, ax_valid, ax_ovf, ax_rnd;
  logic [N-1:0] ax_data [3];

  int checks = 0;
  int passes = 0;

  always #5 i_clk = ~i_clk;

  man_mul_iter #(.SIZE_DATA(N), .RADIX_BITS(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .o_valid(o_valid), .i_ready(i_ready),
    .o_data_mul(o_data_mul), .o_over_flag(o_over_flag), .o_rounding(o_rounding)
  );

  for (genvar g = 0; g < 3; g++) begin : g_aux
    man_mul_iter #(.SIZE_DATA(N), .RADIX_BITS(g == 0 ? 1 : (g == 1 ? 3 : 4))) u_aux (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(aux_valid), .o_ready(ax_ready[g]),
      .i_data_a(i_data_a), .i_data_b(i_data_b), .o_valid(ax_valid[g]), .i_ready(i_ready),
      .o_data_mul(ax_data[g]), .o_over_flag(ax_ovf[g]), .o_rounding(ax_rnd[g])
    );
  end

  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    i_valid = 1'b1; i_data_a = a; i_data_b = b;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge i_clk); #1;
      if (o_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic finish_op;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0)
      $display("FAIL reset_handshake: ready=%b valid=%b, want ready=1 valid=0", o_ready, o_valid);
    else passes++;
    checks++;
    if (o_data_mul !== '0 || o_over_flag !== 1'b0 || o_rounding !== 1'b0)
      $display("FAIL reset_outputs: data=%h ovf=%b rnd=%b, want 0/0/0", o_data_mul, o_over_flag, o_rounding);
    else passes++;
    checks++;
    if (ax_ready !== 3'b111 || ax_valid !== 3'b000)
      $display("FAIL reset_aux: ready=%b valid=%b, want 111/000", ax_ready, ax_valid);
    else passes++;
    #2 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    checks++;
    if (o_ready !== 1'b1) $display("FAIL reset_release: ready=%b, want 1", o_ready);
    else passes++;
  endtask

  task automatic test_unity;
    int lat;
    start_op(24'h800000, 24'h800000);
    wait_valid(lat);
    checks++;
    if (lat != 13) $display("FAIL unity_latency: got %0d, want 13", lat);
    else passes++;
    checks++;
    if (o_data_mul !== 24'h800000 || o_over_flag !== 1'b0 || o_rounding !== 1'b0)
      $display("FAIL unity_result: data=%h ovf=%b rnd=%b, want 800000/0/0", o_data_mul, o_over_flag, o_rounding);
    else passes++;
    finish_op();
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0)
      $display("FAIL unity_return: ready=%b valid=%b, want 1/0", o_ready, o_valid);
    else passes++;
  endtask

  task automatic test_overflow;
    int lat;
    start_op(24'hC00000, 24'hC00000);
    wait_valid(lat);
    checks++;
    if (lat != 13) $display("FAIL ovf_latency: got %0d, want 13", lat);
    else passes++;
    checks++;
    if (o_data_mul !== 24'h900000 || o_over_flag !== 1'b1 || o_rounding !== 1'b0)
      $display("FAIL ovf_result: data=%h ovf=%b rnd=%b, want 900000/1/0", o_data_mul, o_over_flag, o_rounding);
    else passes++;
    finish_op();
  endtask

  task automatic test_rounding;
    logic [N-1:0] va [2];
    logic [N-1:0] exp_m [2];
    logic         exp_r [2];
    int lat;
    va[0] = 24'h800001; exp_r[0] = 1'b1;
`ifdef MAN_MUL_ROUND_APPLY_EN
    exp_m[0] = 24'hC00002;
`else
    exp_m[0] = 24'hC00001;
`endif
    va[1] = 24'h800003; exp_r[1] = 1'b0; exp_m[1] = 24'hC00004;
    for (int i = 0; i < 2; i++) begin
      start_op(va[i], 24'hC00000);
      wait_valid(lat);
      checks++;
      if (lat != 13 || o_data_mul !== exp_m[i] || o_over_flag !== 1'b0 || o_rounding !== exp_r[i])
        $display("FAIL tie_%0d: lat=%0d data=%h ovf=%b rnd=%b, want 13/%h/0/%b",
                 i, lat, o_data_mul, o_over_flag, o_rounding, exp_m[i], exp_r[i]);
      else passes++;
      finish_op();
    end
  endtask

  task automatic test_hold;
    int lat;
    start_op(24'hFFFFFF, 24'hFFFFFF);
    wait_valid(lat);
    checks++;
    if (lat != 13 || o_data_mul !== 24'hFFFFFE || o_over_flag !== 1'b1 || o_rounding !== 1'b0)
      $display("FAIL max_result: lat=%0d data=%h ovf=%b rnd=%b, want 13/fffffe/1/0",
               lat, o_data_mul, o_over_flag, o_rounding);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      i_valid = (i == 1 || i == 3);
      i_data_a = 24'h800000; i_data_b = 24'h800000;
      @(posedge i_clk); #1;
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data_mul !== 24'hFFFFFE ||
          o_over_flag !== 1'b1 || o_rounding !== 1'b0)
        $display("FAIL hold_%0d: valid=%b ready=%b data=%h ovf=%b rnd=%b, want 1/0/fffffe/1/0",
                 i, o_valid, o_ready, o_data_mul, o_over_flag, o_rounding);
      else passes++;
    end
    i_valid = 1'b0;
    finish_op();
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0)
      $display("FAIL hold_release: ready=%b valid=%b, want 1/0", o_ready, o_valid);
    else passes++;
  endtask

  task automatic test_reset_abort;
    int lat;
    start_op(24'hFFFFFF, 24'hFFFFFF);
    repeat (5) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data_mul !== '0 ||
        o_over_flag !== 1'b0 || o_rounding !== 1'b0)
      $display("FAIL abort_clear: valid=%b ready=%b data=%h ovf=%b rnd=%b, want 0/1/0/0/0",
               o_valid, o_ready, o_data_mul, o_over_flag, o_rounding);
    else passes++;
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0)
      $display("FAIL abort_idle: ready=%b valid=%b, want 1/0", o_ready, o_valid);
    else passes++;
    start_op(24'hC00000, 24'hC00000);
    wait_valid(lat);
    checks++;
    if (lat != 13 || o_data_mul !== 24'h900000 || o_over_flag !== 1'b1)
      $display("FAIL abort_rerun: lat=%0d data=%h ovf=%b, want 13/900000/1", lat, o_data_mul, o_over_flag);
    else passes++;
    finish_op();
  endtask

  task automatic test_back_to_back;
    int lat;
    start_op(24'h800000, 24'h800000);
    wait_valid(lat);
    i_ready = 1'b1; i_valid = 1'b1;
    i_data_a = 24'hC00000; i_data_b = 24'hC00000;
    @(posedge i_clk); #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0)
      $display("FAIL b2b_exit: ready=%b valid=%b, want 1/0", o_ready, o_valid);
    else passes++;
    @(posedge i_clk); #1;
    checks++;
    if (o_ready !== 1'b0) $display("FAIL b2b_accept: ready=%b, want 0", o_ready);
    else passes++;
    i_valid = 1'b0; i_ready = 1'b0;
    wait_valid(lat);
    checks++;
    if (lat != 13 || o_data_mul !== 24'h900000 || o_over_flag !== 1'b1)
      $display("FAIL b2b_result: lat=%0d data=%h ovf=%b, want 13/900000/1", lat, o_data_mul, o_over_flag);
    else passes++;
    finish_op();
  endtask

  task automatic test_radix;
    int lat [3];
    int want [3];
    want[0] = 25; want[1] = 9; want[2] = 7;
    for (int g = 0; g < 3; g++) lat[g] = -1;
    aux_valid = 1'b1; i_data_a = 24'hC00000; i_data_b = 24'hC00000;
    @(posedge i_clk); #1;
    aux_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge i_clk); #1;
      for (int g = 0; g < 3; g++) if (ax_valid[g] && lat[g] < 0) lat[g] = c;
    end
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (lat[g] != want[g] || ax_data[g] !== 24'h900000 || ax_ovf[g] !== 1'b1 || ax_rnd[g] !== 1'b0)
        $display("FAIL radix_%0d: lat=%0d data=%h ovf=%b rnd=%b, want %0d/900000/1/0",
                 g, lat[g], ax_data[g], ax_ovf[g], ax_rnd[g], want[g]);
      else passes++;
    end
    finish_op();
    checks++;
    if (ax_ready !== 3'b111 || ax_valid !== 3'b000)
      $display("FAIL radix_return: ready=%b valid=%b, want 111/000", ax_ready, ax_valid);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_unity();
    test_overflow();
    test_rounding();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    test_radix();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule
